// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one byte-wide synchronous RAM port between the instruction fetcher
// and the load/store buffer (LSB). Word fetches and 1/2/4-byte loads/stores
// are broken into byte transfers. Read bytes are assembled little-endian.
// The fetcher and LSB are arbitrated round-robin. A ROB flush drops reads in
// flight. I/O-space stores stall while the host output buffer is full.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   is_exception_from_rob     flush: aborts fetch/load, blocks new reads
//   is_request_from_fetcher   level request, 4-byte read at pc_from_fetcher
//   is_done_to_fetcher        1-cycle pulse, instr_to_fetcher valid
//   is_request_from_lsb       level request, load or store
//   is_write_from_lsb         1 = store, 0 = load
//   addr_from_lsb             base address
//   size_from_lsb             1, 2 or 4 bytes; other values mean 4
//   data_from_lsb             store data, byte k at bits [8k+7:8k]
//   is_done_to_lsb            1-cycle pulse, load data valid / store done
//   data_to_lsb               zero-extended load data
//   mem_din/mem_dout/mem_a/mem_wr  RAM port (read data is returned one
//                             cycle after its address)
//   io_buffer_full            host buffer full, stalls I/O stores
//   fsm_state                 current FSM state, for observation only
//
// Handshake: a requester raises its request and holds it, with stable
// address/size/data, until it sees its done pulse. The request is ignored
// in the cycle its done is high, so dropping it in that cycle is safe.
// Address, size and store data are latched at the grant edge.
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int         AddrWidth = 32,
    parameter logic [1:0] IoSpace   = 2'b11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 is_exception_from_rob,
    input  logic                 is_request_from_fetcher,
    input  logic [AddrWidth-1:0] pc_from_fetcher,
    output logic                 is_done_to_fetcher,
    output logic [31:0]          instr_to_fetcher,
    input  logic                 is_request_from_lsb,
    input  logic                 is_write_from_lsb,
    input  logic [AddrWidth-1:0] addr_from_lsb,
    input  logic [2:0]           size_from_lsb,
    input  logic [31:0]          data_from_lsb,
    output logic                 is_done_to_lsb,
    output logic [31:0]          data_to_lsb,
    input  logic [7:0]           mem_din,
    output logic [7:0]           mem_dout,
    output logic [AddrWidth-1:0] mem_a,
    output logic                 mem_wr,
    input  logic                 io_buffer_full,
    output logic [1:0]           fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        STORE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [AddrWidth-1:0] base_q;
    logic [2:0]           cnt_q;       // byte index, 0..4
    logic [2:0]           size_q;      // byte count N of current transfer
    logic [31:0]          asm_q;       // read assembly buffer
    logic [31:0]          wdata_q;     // latched store data
    logic                 last_grant_q; // 1 = LSB was granted last
    logic                 done_fetch_q;
    logic                 done_lsb_q;
    logic [31:0]          instr_q;
    logic [31:0]          data_lsb_q;

    logic                 fetch_req;
    logic                 lsb_req;
    logic                 grant_lsb;
    logic                 grant_fetch;
    logic [2:0]           lsb_size;
    logic                 io_hold;
    logic                 store_last;
    logic                 read_last;
    logic [31:0]          capture_word;
    logic [7:0]           store_byte;

    // ------------------------------------------------------------------
    // Request qualification and arbitration
    // ------------------------------------------------------------------
    // A flush at the grant edge blocks reads only; stores reaching this
    // block are already committed and must proceed.
    assign fetch_req = is_request_from_fetcher && !done_fetch_q && !is_exception_from_rob;
    assign lsb_req   = is_request_from_lsb && !done_lsb_q &&
                       !(is_exception_from_rob && !is_write_from_lsb);

    // Round-robin tie break: LSB wins unless it was the last one granted.
    assign grant_lsb   = (state_q == IDLE) && lsb_req && (!fetch_req || !last_grant_q);
    assign grant_fetch = (state_q == IDLE) && fetch_req && !grant_lsb;

    always_comb begin
        case (size_from_lsb)
            3'd1:    lsb_size = 3'd1;
            3'd2:    lsb_size = 3'd2;
            default: lsb_size = 3'd4;
        endcase
    end

    // ------------------------------------------------------------------
    // Transfer bookkeeping
    // ------------------------------------------------------------------
    assign io_hold    = (state_q == STORE) && (base_q[17:16] == IoSpace) && io_buffer_full;
    assign store_last = (cnt_q == size_q - 3'd1) && !io_hold;
    // Reads run N address cycles plus one trailing capture cycle, so the
    // transfer ends when cnt reaches N rather than N-1.
    assign read_last  = (cnt_q == size_q);

    // The byte returned now belongs to the address issued last cycle,
    // i.e. byte index cnt-1.
    always_comb begin
        capture_word = asm_q;
        case (cnt_q)
            3'd1:    capture_word[7:0]   = mem_din;
            3'd2:    capture_word[15:8]  = mem_din;
            3'd3:    capture_word[23:16] = mem_din;
            3'd4:    capture_word[31:24] = mem_din;
            default: capture_word = asm_q;
        endcase
    end

    always_comb begin
        case (cnt_q[1:0])
            2'd0:    store_byte = wdata_q[7:0];
            2'd1:    store_byte = wdata_q[15:8];
            2'd2:    store_byte = wdata_q[23:16];
            default: store_byte = wdata_q[31:24];
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and RAM port outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        mem_a    = '0;
        mem_wr   = 1'b0;
        mem_dout = 8'h00;
        case (state_q)
            IDLE: begin
                if (grant_lsb) begin
                    state_d = is_write_from_lsb ? STORE : LOAD;
                end else if (grant_fetch) begin
                    state_d = FETCH;
                end
            end
            FETCH, LOAD: begin
                if (cnt_q < size_q) begin
                    mem_a = base_q + AddrWidth'(cnt_q);
                end
                if (is_exception_from_rob || read_last) begin
                    state_d = IDLE;
                end
            end
            STORE: begin
                mem_a    = base_q + AddrWidth'(cnt_q);
                mem_dout = store_byte;
                mem_wr   = !io_hold;
                if (store_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q       <= '0;
            cnt_q        <= 3'd0;
            size_q       <= 3'd4;
            asm_q        <= 32'h0;
            wdata_q      <= 32'h0;
            last_grant_q <= 1'b0;
            done_fetch_q <= 1'b0;
            done_lsb_q   <= 1'b0;
            instr_q      <= 32'h0;
            data_lsb_q   <= 32'h0;
        end else begin
            done_fetch_q <= 1'b0;
            done_lsb_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= 3'd0;
                    if (grant_lsb) begin
                        base_q       <= addr_from_lsb;
                        size_q       <= lsb_size;
                        wdata_q      <= data_from_lsb;
                        asm_q        <= 32'h0;
                        last_grant_q <= 1'b1;
                    end else if (grant_fetch) begin
                        base_q       <= pc_from_fetcher;
                        size_q       <= 3'd4;
                        asm_q        <= 32'h0;
                        last_grant_q <= 1'b0;
                    end
                end
                FETCH, LOAD: begin
                    if (is_exception_from_rob) begin
                        cnt_q <= 3'd0;
                    end else begin
                        if (cnt_q != 3'd0) begin
                            asm_q <= capture_word;
                        end
                        if (read_last) begin
                            cnt_q <= 3'd0;
                            if (state_q == FETCH) begin
                                done_fetch_q <= 1'b1;
                                instr_q      <= capture_word;
                            end else begin
                                done_lsb_q <= 1'b1;
                                data_lsb_q <= capture_word;
                            end
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                end
                STORE: begin
                    // cnt is frozen while an I/O store is held off.
                    if (!io_hold) begin
                        if (store_last) begin
                            cnt_q      <= 3'd0;
                            done_lsb_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                end
                default: cnt_q <= 3'd0;
            endcase
        end
    end

    assign is_done_to_fetcher = done_fetch_q;
    assign instr_to_fetcher   = instr_q;
    assign is_done_to_lsb     = done_lsb_q;
    assign data_to_lsb        = data_lsb_q;
    assign fsm_state          = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter: self-checking bench for mem_arbiter with a byte RAM model.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req_f;
    logic [31:0] pc;
    logic        done_f;
    logic [31:0] instr;
    logic        req_l;
    logic        wr_l;
    logic [31:0] addr_l;
    logic [2:0]  size_l;
    logic [31:0] wdata_l;
    logic        done_l;
    logic [31:0] data_lsb;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_full;
    logic [1:0]  fsm_state;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] exp_data_q[$];   // expected read results
    logic [39:0] exp_wr_q[$];     // expected RAM writes {addr, byte}
    logic [40:0] exp_done_q[$];   // {is_lsb, cycle, data} for arbitration

    logic [7:0] ram [0:262143];

    mem_arbiter dut (
        .clk                     (clk),
        .rst                     (rst),
        .is_exception_from_rob   (flush),
        .is_request_from_fetcher (req_f),
        .pc_from_fetcher         (pc),
        .is_done_to_fetcher      (done_f),
        .instr_to_fetcher        (instr),
        .is_request_from_lsb     (req_l),
        .is_write_from_lsb       (wr_l),
        .addr_from_lsb           (addr_l),
        .size_from_lsb           (size_l),
        .data_from_lsb           (wdata_l),
        .is_done_to_lsb          (done_l),
        .data_to_lsb             (data_lsb),
        .mem_din                 (mem_din),
        .mem_dout                (mem_dout),
        .mem_a                   (mem_a),
        .mem_wr                  (mem_wr),
        .io_buffer_full          (io_full),
        .fsm_state               (fsm_state)
    );

    // ---------------- clock / RAM model ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_din <= ram[mem_a[17:0]];
        if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; req_f = 0; pc = 0; req_l = 0; wr_l = 0;
        addr_l = 0; size_l = 0; wdata_l = 0; io_full = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_read(input logic is_fetch, input logic [31:0] addr,
                           input logic [2:0] size, input logic [31:0] exp_word);
        int n;
        bit seen;
        logic done;
        logic [31:0] got, exp;
        n = (size == 3'd1 || size == 3'd2) ? int'(size) : 4;
        exp_data_q.push_back(exp_word);
        if (is_fetch) begin
            req_f = 1; pc = addr;
        end else begin
            req_l = 1; wr_l = 0; addr_l = addr; size_l = size;
        end
        tick();
        seen = 0;
        for (int c = 0; c < n + 4 && !seen; c++) begin
            if (c < n) begin
                tests_run++;
                if (mem_a !== addr + 32'(c) || mem_wr !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL read_addr: cycle %0d mem_a=%h mem_wr=%b, expected mem_a=%h mem_wr=0",
                             c, mem_a, mem_wr, addr + 32'(c));
                end
            end
            done = is_fetch ? done_f : done_l;
            got  = is_fetch ? instr : data_lsb;
            if (done === 1'b1) begin
                seen = 1;
                exp  = exp_data_q.pop_front();
                tests_run++;
                if (got !== exp || c != n + 1) begin
                    tests_failed++;
                    $display("FAIL read_result: data=%h at cycle %0d, expected %h at cycle %0d",
                             got, c, exp, n + 1);
                end
                req_f = 0; req_l = 0;
            end
            tick();
        end
        if (!seen) begin
            tests_run++; tests_failed++;
            $display("FAIL read_timeout: no done, expected data %h", exp_word);
            void'(exp_data_q.pop_front());
            req_f = 0; req_l = 0;
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [2:0] size,
                            input logic [31:0] data, input int hold,
                            input int flush_at, input bit flush_grant);
        int n;
        bit seen;
        logic [31:0] a;
        logic [39:0] exp;
        n = (size == 3'd1 || size == 3'd2) ? int'(size) : 4;
        for (int k = 0; k < n; k++) begin
            a = addr + 32'(k);
            exp_wr_q.push_back({a, data[8*k +: 8]});
        end
        req_l = 1; wr_l = 1; addr_l = addr; size_l = size; wdata_l = data;
        flush = flush_grant;
        tick();
        seen = 0;
        for (int c = 0; c < n + hold + 3 && !seen; c++) begin
            io_full = (c < hold);
            flush   = (c == flush_at);
            #1;
            if (c < hold) begin
                tests_run++;
                if (mem_wr !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL io_hold: cycle %0d mem_wr=%b, expected 0", c, mem_wr);
                end
            end
            if (mem_wr === 1'b1) begin
                tests_run++;
                if (exp_wr_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL write_extra: mem_a=%h mem_dout=%h, expected no write", mem_a, mem_dout);
                end else begin
                    exp = exp_wr_q.pop_front();
                    if ({mem_a, mem_dout} !== exp) begin
                        tests_failed++;
                        $display("FAIL write_data: addr=%h byte=%h, expected addr=%h byte=%h",
                                 mem_a, mem_dout, exp[39:8], exp[7:0]);
                    end
                end
            end
            if (done_l === 1'b1) begin
                seen = 1;
                tests_run++;
                if (c != n + hold) begin
                    tests_failed++;
                    $display("FAIL write_latency: done at cycle %0d, expected %0d", c, n + hold);
                end
                req_l = 0;
            end
            tick();
        end
        io_full = 0; flush = 0;
        tests_run++;
        if (!seen || exp_wr_q.size() != 0) begin
            tests_failed++;
            $display("FAIL write_complete: done_seen=%0d pending_writes=%0d, expected 1 and 0",
                     seen, exp_wr_q.size());
            exp_wr_q.delete();
            req_l = 0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        tests_run++;
        if ({done_f, done_l, mem_wr} !== 3'b000 || instr !== 32'h0 || data_lsb !== 32'h0 ||
            mem_a !== 32'h0 || mem_dout !== 8'h0 || fsm_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_values: done_f=%b done_l=%b mem_wr=%b instr=%h data=%h mem_a=%h dout=%h st=%0d, expected all 0",
                     done_f, done_l, mem_wr, instr, data_lsb, mem_a, mem_dout, fsm_state);
        end
        rst = 0;
    endtask

    task automatic test_arbitration();
        logic [40:0] exp;
        apply_reset();
        exp_done_q.push_back({1'b1, 8'd2,  32'h000000FF});
        exp_done_q.push_back({1'b0, 8'd8,  32'h00000513});
        exp_done_q.push_back({1'b1, 8'd11, 32'h000000FF});
        exp_done_q.push_back({1'b0, 8'd17, 32'h00000513});
        exp_done_q.push_back({1'b1, 8'd20, 32'h000000FF});
        req_f = 1; pc = 32'h1000;
        req_l = 1; wr_l = 0; addr_l = 32'h20; size_l = 3'd1;
        tick();
        tests_run++;
        if (mem_a !== 32'h20) begin
            tests_failed++;
            $display("FAIL first_grant: mem_a=%h, expected 00000020 (LSB first)", mem_a);
        end
        for (int c = 0; c <= 20; c++) begin
            if (c == 20) begin req_f = 0; req_l = 0; end
            if (done_f === 1'b1 || done_l === 1'b1) begin
                tests_run++;
                if (exp_done_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL arb_extra_done: cycle %0d done_f=%b done_l=%b", c, done_f, done_l);
                end else begin
                    exp = exp_done_q.pop_front();
                    if ({done_l, 8'(c), done_l ? data_lsb : instr} !== exp || done_f === done_l) begin
                        tests_failed++;
                        $display("FAIL arb_order: lsb=%b cycle=%0d data=%h, expected lsb=%b cycle=%0d data=%h",
                                 done_l, c, done_l ? data_lsb : instr, exp[40], exp[39:32], exp[31:0]);
                    end
                end
            end
            tick();
        end
        tests_run++;
        if (exp_done_q.size() != 0) begin
            tests_failed++;
            $display("FAIL arb_missing: %0d done pulses not seen, expected 0", exp_done_q.size());
            exp_done_q.delete();
        end
    endtask

    task automatic test_fetch();
        do_read(1'b1, 32'h1000, 3'd4, 32'h00000513);
    endtask

    task automatic test_store();
        do_write(32'h100, 3'd2, 32'h0000ABCD, 0, -1, 1'b0);
    endtask

    task automatic test_sizes();
        do_read(1'b0, 32'h100,  3'd2, 32'h0000ABCD);
        do_read(1'b0, 32'h101,  3'd1, 32'h000000AB);
        do_read(1'b0, 32'h1000, 3'd5, 32'h00000513);
    endtask

    task automatic test_flush();
        bit seen;
        exp_data_q.push_back(32'h00100093);
        req_f = 1; pc = 32'h1000;
        tick();                       // cycle 0
        tick();                       // cycle 1
        flush = 1;
        tick();                       // cycle 2, flush sampled at E2
        flush = 0; pc = 32'h2000;
        tests_run++;
        if (mem_a !== 32'h0 || done_f !== 1'b0 || fsm_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL flush_abort: mem_a=%h done_f=%b st=%0d, expected 0 0 0", mem_a, done_f, fsm_state);
        end
        tick();                       // cycle 3
        tests_run++;
        if (mem_a !== 32'h2000) begin
            tests_failed++;
            $display("FAIL flush_regrant: mem_a=%h, expected 00002000", mem_a);
        end
        seen = 0;
        for (int c = 3; c < 12 && !seen; c++) begin
            if (done_f === 1'b1) begin
                seen = 1;
                tests_run++;
                if (instr !== exp_data_q[0] || c != 8) begin
                    tests_failed++;
                    $display("FAIL flush_refetch: instr=%h at cycle %0d, expected %h at cycle 8",
                             instr, c, exp_data_q[0]);
                end
                void'(exp_data_q.pop_front());
                req_f = 0;
            end
            tick();
        end
        if (!seen) begin
            tests_run++; tests_failed++;
            $display("FAIL flush_refetch_timeout: no done, expected instr 00100093");
            exp_data_q.delete();
            req_f = 0;
        end
    endtask

    task automatic test_flush_idle();
        flush = 1;
        req_f = 1; pc = 32'h1000;
        req_l = 1; wr_l = 0; addr_l = 32'h20; size_l = 3'd1;
        tick();
        tests_run++;
        if (fsm_state !== 2'd0 || mem_a !== 32'h0) begin
            tests_failed++;
            $display("FAIL flush_blocks_reads: st=%0d mem_a=%h, expected 0 0", fsm_state, mem_a);
        end
        idle_inputs();
        do_write(32'h200, 3'd4, 32'h12345678, 0, -1, 1'b1);
    endtask

    task automatic test_io_store();
        do_write(32'h30000, 3'd1, 32'h00000041, 3, 1, 1'b0);
    endtask

    task automatic test_wrap_and_reset();
        do_read(1'b0, 32'hFFFFFFFE, 3'd4, 32'h44332211);
        req_l = 1; wr_l = 0; addr_l = 32'hFFFFFFFE; size_l = 3'd4;
        tick();                       // cycle 0
        tick();                       // cycle 1
        rst = 1;
        tick();                       // reset sampled at E2
        rst = 0; req_l = 0;
        tests_run++;
        if ({done_f, done_l, mem_wr} !== 3'b000 || instr !== 32'h0 || data_lsb !== 32'h0 ||
            mem_a !== 32'h0 || mem_dout !== 8'h0 || fsm_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_read: done_f=%b done_l=%b mem_wr=%b instr=%h data=%h mem_a=%h st=%0d, expected all 0",
                     done_f, done_l, mem_wr, instr, data_lsb, mem_a, fsm_state);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            tests_run++;
            if (done_l !== 1'b0 || mem_wr !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_no_done: cycle %0d done_l=%b mem_wr=%b, expected 0 0", c, done_l, mem_wr);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
        ram[18'h01000] = 8'h13; ram[18'h01001] = 8'h05;
        ram[18'h01002] = 8'h00; ram[18'h01003] = 8'h00;
        ram[18'h02000] = 8'h93; ram[18'h02001] = 8'h00;
        ram[18'h02002] = 8'h10; ram[18'h02003] = 8'h00;
        ram[18'h00020] = 8'hFF;
        ram[18'h3FFFE] = 8'h11; ram[18'h3FFFF] = 8'h22;
        ram[18'h00000] = 8'h33; ram[18'h00001] = 8'h44;
        idle_inputs();
        rst = 1;

        test_reset();
        test_arbitration();
        test_fetch();
        test_store();
        test_sizes();
        test_flush();
        test_flush_idle();
        test_io_store();
        test_wrap_and_reset();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
